// File: rtl/edp_pkg.sv
// edp_pkg: shared ALU function codes and carry helper for the EDP fast-memory/ALU slice
package edp_pkg;
  localparam int ALU_SLICES = 9;
  typedef enum logic {ALU_M_ARITH = 1'b0, ALU_M_LOGIC = 1'b1} alu_mode_e;
  localparam logic [3:0] ALU_A      = 4'd0;
  localparam logic [3:0] ALU_ONES_A = 4'd3;
  localparam logic [3:0] ALU_SUB_M1 = 4'd6;
  localparam logic [3:0] ALU_ADD    = 4'd9;
  localparam logic [3:0] ALU_DBL    = 4'd12;
  localparam logic [3:0] ALU_DEC    = 4'd15;
  localparam logic [3:0] ALU_NOT_A  = 4'd0;
  localparam logic [3:0] ALU_ZERO   = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd6;
  localparam logic [3:0] ALU_PASS_B = 4'd10;
  localparam logic [3:0] ALU_AND    = 4'd11;
  localparam logic [3:0] ALU_ONES_L = 4'd12;
  localparam logic [3:0] ALU_OR     = 4'd14;
  localparam logic [3:0] ALU_PASS_A = 4'd15;
  // Carry out of one slice/group from its generate, propagate and carry-in.
  function automatic logic gp_carry(logic g, logic p, logic cin);
    return g | (p & cin);
  endfunction
endpackage

// File: rtl/mc10179.sv
// mc10179: 4-group carry lookahead (group 0 most significant, group 3 least)
//   g, p   : group generate / propagate     cin : carry into group 3
//   gg, pg : block generate / propagate
//   c2out  : carry out of group 2           c8out : carry out of group 0
module mc10179 (
  input  logic [0:3] g,
  input  logic [0:3] p,
  input  logic       cin,
  output logic       gg,
  output logic       pg,
  output logic       c2out,
  output logic       c8out
);
  always_comb begin
    gg = g[0] | (p[0] & g[1]) | (p[0] & p[1] & g[2]) | (p[0] & p[1] & p[2] & g[3]);
    pg = &p;
    c2out = g[2] | (p[2] & g[3]) | (p[2] & p[3] & cin);
    c8out = gg | (pg & cin);
  end
endmodule

// File: rtl/mc10181.sv
// mc10181: 4-bit ALU slice (bit 0 MSB, bit 3 LSB)
//   a, b   : operands        s, m : function code / logic mode
//   cin    : carry into bit 3
//   f      : result          cg, cp : slice carry generate / propagate
module mc10181 (
  input  logic [0:3] a,
  input  logic [0:3] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [0:3] f,
  output logic       cg,
  output logic       cp
);
  // Every function is x + y (+cin) with y a subset of x, so x is the bit
  // propagate and y the bit generate; logic mode is the carry-free ~(x^y).
  logic [0:3] x, y;
  logic [0:4] c;
  always_comb begin
    x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    c = '0;
    c[4] = cin;
    for (int i = 3; i >= 0; i--) c[i] = y[i] | (x[i] & c[i+1]);
    f = m ? ~(x ^ y) : (x ^ y ^ c[1:4]);
    cg = y[0] | (x[0] & y[1]) | (x[0] & x[1] & y[2]) | (x[0] & x[1] & x[2] & y[3]);
    cp = &x;
  end
endmodule

// File: rtl/edp_fm_alu.sv
// edp_fm_alu: fast memory, B-operand mux, 36-bit lookahead ALU and result register
//   CLK, RESET_n          : clock, async active-low reset (clears ad_q/cry_q only)
//   fm_addr/fm_we/fm_din  : FM address, half-word write enables, write data
//   fm_dout/fm_parity     : combinational FM read data and its XOR parity
//   ada, adb_sel, adb_ext : A operand; B = adb_sel ? adb_ext : fm_dout
//   alu_m, alu_s, cry_in  : mode, function code, carry into bit 35
//   ad, cry_out           : combinational result and carry out of bit 0
//   ad_load, ad_q, cry_q  : result register load enable and registered outputs
module edp_fm_alu
  import edp_pkg::*;
#(
  parameter int FM_ADDR_W = 7
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic [FM_ADDR_W-1:0] fm_addr,
  input  logic [1:0]           fm_we,
  input  logic [0:35]          fm_din,
  output logic [0:35]          fm_dout,
  output logic                 fm_parity,
  input  logic [0:35]          ada,
  input  logic                 adb_sel,
  input  logic [0:35]          adb_ext,
  input  logic                 alu_m,
  input  logic [3:0]           alu_s,
  input  logic                 cry_in,
  input  logic                 ad_load,
  output logic [0:35]          ad,
  output logic                 cry_out,
  output logic [0:35]          ad_q,
  output logic                 cry_q
);
  logic [0:35] fm_mem [2**FM_ADDR_W];
  logic [0:35] adb;
  logic [0:8]  cg, cp, cin_s;
  logic        gg_lo, pg_lo, gg_hi, pg_hi, gg_top, pg_top, c8_hi, c_top;
  logic        la_unused;
  logic [0:35] ad_d;
  logic        cry_d;
  // Memory is deliberately not reset; writes are only blocked while in reset.
  always_ff @(posedge CLK) begin
    if (RESET_n && fm_we[1]) fm_mem[fm_addr][0:17] <= fm_din[0:17];
    if (RESET_n && fm_we[0]) fm_mem[fm_addr][18:35] <= fm_din[18:35];
  end
  assign fm_dout = fm_mem[fm_addr];
  assign fm_parity = ^fm_dout;
  assign adb = adb_sel ? adb_ext : fm_dout;
  for (genvar i = 0; i < ALU_SLICES; i++) begin : g_slice
    mc10181 u_slice (
      .a  (ada[4*i +: 4]),
      .b  (adb[4*i +: 4]),
      .s  (alu_s),
      .m  (alu_m),
      .cin(cin_s[i]),
      .f  (ad[4*i +: 4]),
      .cg (cg[i]),
      .cp (cp[i])
    );
  end
  // First level: slices 5..8 and 1..4; slice 0 joins at the second level.
  mc10179 u_la_lo (
    .g(cg[5:8]), .p(cp[5:8]), .cin(cry_in),
    .gg(gg_lo), .pg(pg_lo), .c2out(cin_s[6]), .c8out(cin_s[4])
  );
  mc10179 u_la_hi (
    .g(cg[1:4]), .p(cp[1:4]), .cin(cin_s[4]),
    .gg(gg_hi), .pg(pg_hi), .c2out(cin_s[2]), .c8out(c8_hi)
  );
  // Group 0 is padded as a transparent propagate so c8out is the carry out of bit 0.
  mc10179 u_la_top (
    .g({1'b0, cg[0], gg_hi, gg_lo}), .p({1'b1, cp[0], pg_hi, pg_lo}), .cin(cry_in),
    .gg(gg_top), .pg(pg_top), .c2out(cin_s[0]), .c8out(c_top)
  );
  assign la_unused = gg_top ^ pg_top ^ c8_hi;
  assign cin_s[8] = cry_in;
  assign cin_s[7] = gp_carry(cg[8], cp[8], cin_s[8]);
  assign cin_s[5] = gp_carry(cg[6], cp[6], cin_s[6]);
  assign cin_s[3] = gp_carry(cg[4], cp[4], cin_s[4]);
  assign cin_s[1] = gp_carry(cg[2], cp[2], cin_s[2]);
  assign cry_out = (alu_m == ALU_M_ARITH) & c_top;
  always_comb begin
    ad_d = ad_load ? ad : ad_q;
    cry_d = ad_load ? cry_out : cry_q;
  end
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ad_q <= '0;
      cry_q <= 1'b0;
    end else begin
      ad_q <= ad_d;
      cry_q <= cry_d;
    end
  end
endmodule

// File: tb/tb_edp_fm_alu.sv
// tb_edp_fm_alu: scoreboard-driven directed and swept checks of edp_fm_alu
module tb_edp_fm_alu;
  import edp_pkg::*;
  localparam int AW = 7;
  logic          CLK = 1'b0;
  logic          RESET_n;
  logic [AW-1:0] fm_addr;
  logic [1:0]    fm_we;
  logic [0:35]   fm_din, fm_dout, ada, adb_ext, ad, ad_q;
  logic          fm_parity, adb_sel, alu_m, cry_in, ad_load, cry_out, cry_q;
  logic [3:0]    alu_s;
  typedef struct {string tag; logic [36:0] exp;} sb_t;
  sb_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  edp_fm_alu #(.FM_ADDR_W(AW)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .fm_addr(fm_addr), .fm_we(fm_we), .fm_din(fm_din),
    .fm_dout(fm_dout), .fm_parity(fm_parity), .ada(ada), .adb_sel(adb_sel),
    .adb_ext(adb_ext), .alu_m(alu_m), .alu_s(alu_s), .cry_in(cry_in),
    .ad_load(ad_load), .ad(ad), .cry_out(cry_out), .ad_q(ad_q), .cry_q(cry_q)
  );

  always #5 CLK = ~CLK;

  // Reference: arithmetic is x + y + cin on 37 bits, "-1" meaning + all-ones.
  function automatic logic [36:0] alu_ref(logic m, logic [3:0] s, logic [35:0] a,
                                          logic [35:0] b, logic cin);
    logic [35:0] o, x, y, l;
    o = '1;
    x = a;
    y = '0;
    l = '0;
    if (m) begin
      case (s)
        4'd0:  l = ~a;
        4'd1:  l = ~(a | b);
        4'd2:  l = ~a & b;
        4'd3:  l = '0;
        4'd4:  l = ~(a & b);
        4'd5:  l = ~b;
        4'd6:  l = a ^ b;
        4'd7:  l = a & ~b;
        4'd8:  l = ~a | b;
        4'd9:  l = ~(a ^ b);
        4'd10: l = b;
        4'd11: l = a & b;
        4'd12: l = o;
        4'd13: l = a | ~b;
        4'd14: l = a | b;
        default: l = a;
      endcase
      return {1'b0, l};
    end
    case (s)
      4'd0:  begin x = a;      y = '0;     end
      4'd1:  begin x = a | b;  y = '0;     end
      4'd2:  begin x = a | ~b; y = '0;     end
      4'd3:  begin x = o;      y = '0;     end
      4'd4:  begin x = a;      y = a & ~b; end
      4'd5:  begin x = a | b;  y = a & ~b; end
      4'd6:  begin x = a;      y = ~b;     end
      4'd7:  begin x = a & ~b; y = o;      end
      4'd8:  begin x = a;      y = a & b;  end
      4'd9:  begin x = a;      y = b;      end
      4'd10: begin x = a | ~b; y = a & b;  end
      4'd11: begin x = a & b;  y = o;      end
      4'd12: begin x = a;      y = a;      end
      4'd13: begin x = a | b;  y = a;      end
      4'd14: begin x = a | ~b; y = a;      end
      default: begin x = a;    y = o;      end
    endcase
    return {1'b0, x} + {1'b0, y} + {36'd0, cin};
  endfunction

  task automatic push(input string tag, input logic [36:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic check(input logic [36:0] obs);
    sb_t t;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %o required an entry", obs);
    end else begin
      t = sb.pop_front();
      assert (obs === t.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %o expected %o", t.tag, obs, t.exp);
      end
    end
  endtask

  task automatic fm_check(input string tag, input logic [35:0] w);
    push(tag, {^w, w});
    check({fm_parity, fm_dout});
  endtask

  task automatic fm_write(input logic [AW-1:0] a, input logic [1:0] we, input logic [35:0] d);
    @(negedge CLK);
    fm_addr = a;
    fm_we = we;
    fm_din = d;
    @(negedge CLK);
    fm_we = 2'b00;
    #1;
  endtask

  task automatic alu_drive(input logic m, input logic [3:0] s, input logic [35:0] a,
                           input logic [35:0] b, input logic cin);
    @(negedge CLK);
    adb_sel = 1'b1;
    alu_m = m;
    alu_s = s;
    ada = a;
    adb_ext = b;
    cry_in = cin;
  endtask

  task automatic alu_ref_check(input string tag, input logic m, input logic [3:0] s,
                               input logic [35:0] a, input logic [35:0] b, input logic cin);
    alu_drive(m, s, a, b, cin);
    push(tag, alu_ref(m, s, a, b, cin));
    #1 check({cry_out, ad});
  endtask

  task automatic alu_k(input string tag, input logic m, input logic [3:0] s,
                       input logic [35:0] a, input logic [35:0] b, input logic cin,
                       input logic [36:0] e);
    alu_drive(m, s, a, b, cin);
    push(tag, e);
    #1 check({cry_out, ad});
  endtask

  initial begin
    logic [63:0] r;
    logic [35:0] ra, rb;
    RESET_n = 1'b0;
    fm_addr = '0;
    fm_we = 2'b00;
    fm_din = '0;
    ada = '0;
    adb_sel = 1'b1;
    adb_ext = '0;
    alu_m = 1'b0;
    alu_s = 4'd0;
    cry_in = 1'b0;
    ad_load = 1'b0;
    #1;
    push("reset_regs", 37'd0);
    check({cry_q, ad_q});
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;

    fm_write(7'd5, 2'b11, 36'o123456654321);
    fm_check("fm_full_write", 36'o123456654321);
    fm_write(7'd5, 2'b10, 36'o777777000000);
    fm_check("fm_left_half", 36'o777777654321);
    fm_write(7'd9, 2'b11, 36'o000000000017);
    fm_write(7'd9, 2'b01, 36'o111111222222);
    fm_check("fm_right_half", 36'o000000222222);
    @(negedge CLK);
    fm_addr = 7'd9;
    fm_we = 2'b11;
    fm_din = 36'o555555555555;
    #1 fm_check("fm_rw_before_edge", 36'o000000222222);
    @(posedge CLK);
    #1 fm_check("fm_rw_after_edge", 36'o555555555555);
    fm_we = 2'b00;
    fm_addr = 7'd5;
    #1 fm_check("fm_other_addr_holds", 36'o777777654321);

    @(negedge CLK);
    adb_sel = 1'b0;
    alu_m = 1'b1;
    alu_s = ALU_PASS_B;
    ada = '0;
    push("bmux_fm", {1'b0, 36'o777777654321});
    #1 check({cry_out, ad});

    alu_k("add_msb", 1'b0, ALU_ADD, 36'o377777777777, 36'd1, 1'b0, {1'b0, 36'o400000000000});
    alu_k("sub_pos", 1'b0, ALU_SUB_M1, 36'd7, 36'd5, 1'b1, {1'b1, 36'd2});
    alu_k("sub_neg", 1'b0, ALU_SUB_M1, 36'd5, 36'd7, 1'b1, {1'b0, 36'o777777777776});
    alu_k("full_chain", 1'b0, ALU_A, 36'o777777777777, 36'd0, 1'b1, {1'b1, 36'd0});
    alu_k("logic_xor", 1'b1, ALU_XOR, 36'o707070707070, 36'o070707070707, 1'b1,
          {1'b0, 36'o777777777777});

    for (int k = 0; k < 32; k++) begin
      r = {$urandom(), $urandom()};
      ra = r[35:0];
      r = {$urandom(), $urandom()};
      rb = r[35:0];
      alu_ref_check($sformatf("sweep_rand_m%0d_s%0d", k / 16, k % 16), k[4], k[3:0], ra, rb,
                    r[36]);
      alu_ref_check($sformatf("sweep_edge_m%0d_s%0d", k / 16, k % 16), k[4], k[3:0],
                    36'o777777777777, 36'd1, 1'b1);
    end

    alu_drive(1'b0, ALU_DEC, 36'o1235, 36'd0, 1'b0);
    ad_load = 1'b1;
    push("ad_q_load", {1'b1, 36'o1234});
    @(negedge CLK);
    ad_load = 1'b0;
    ada = 36'o777;
    check({cry_q, ad_q});
    @(negedge CLK);
    push("ad_q_hold", {1'b1, 36'o1234});
    check({cry_q, ad_q});

    #2 RESET_n = 1'b0;
    #1;
    push("async_reset", 37'd0);
    check({cry_q, ad_q});
    alu_k("alu_in_reset", 1'b0, ALU_ADD, 36'd3, 36'd4, 1'b1, {1'b0, 36'd8});
    fm_write(7'd5, 2'b11, 36'd0);
    fm_check("fm_kept_in_reset", 36'o777777654321);
    @(negedge CLK);
    RESET_n = 1'b1;
    #1;
    push("scoreboard_drained", 37'd0);
    check({36'd0, sb.size() != 1});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
